ball_engine: RTL and testbench

Multi-ball motion and paint engine for the breakout playfield. Owns the position and direction state of up to `NUM_BALLS` balls and advances them once per video frame. Handles wall bounces, externally reported paddle/brick hits and ball loss. Produces a registered per-pixel ball hit and colour for the pixel mux, alongside the paddle and brick painters.

---
 rtl/ball_engine.sv | 194 +++++++++++++++++++
 tb/tb_ball_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Multi-ball motion/paint engine; optional rounded balls via BALL_ENGINE_ROUND_EN.
// Latency: paint 1 cycle after hpos/vpos; frame update NUM_BALLS+1 cycles after frame_tick.
// No backpressure: launches outside IDLE and frame_ticks while busy are dropped.
module ball_engine #(
  parameter int          NUM_BALLS  = 2,
  parameter int          BALL_WIDTH = 5,
  parameter int          SPEED      = 1,
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter logic [5:0]  BALL_COLOR = 6'b001100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 launch,
  input  logic [9:0]           launch_x,
  input  logic [8:0]           launch_y,
  input  logic [NUM_BALLS-1:0] hit_h,
  input  logic [NUM_BALLS-1:0] hit_v,
  input  logic [9:0]           hpos,
  input  logic [8:0]           vpos,
  output logic                 in_ball,
  output logic [5:0]           color,
  output logic [NUM_BALLS-1:0] active,
  output logic                 launch_ack,
  output logic                 lost,
  output logic                 busy
);
  localparam int HALF = BALL_WIDTH / 2;
  localparam int IW   = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [10:0] HALF_W = 11'(HALF);
  localparam logic [10:0] SPD_W  = 11'(SPEED);
  localparam logic [10:0] XMAX_W = 11'(SCREEN_W - 1 - HALF);
  localparam logic [10:0] YMAX_W = 11'(SCREEN_H - 1);
  localparam logic [9:0]  HALF_X = 10'(HALF);
  localparam logic [8:0]  HALF_Y = 9'(HALF);
  localparam logic [9:0]  SPD_X  = 10'(SPEED);
  localparam logic [8:0]  SPD_Y  = 9'(SPEED);
  localparam logic [9:0]  XMAX_X = 10'(SCREEN_W - 1 - HALF);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [9:0]           x [NUM_BALLS];
  logic [8:0]           y [NUM_BALLS];
  logic [NUM_BALLS-1:0] dx_neg, dy_neg, act, lat_h, lat_v;

  logic          free_vld;
  logic [IW-1:0] free_idx;
  logic          launch_go;

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (!act[i]) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign launch_go = launch && (state == S_IDLE) && !frame_tick && free_vld;

  // Next position of the slot under update; compares widened to 11 bits so nothing wraps.
  logic [10:0] cx, cy;
  logic        dxn, dyn, ndx, ndy, gone;
  logic [9:0]  nx;
  logic [8:0]  ny;

  always_comb begin
    cx   = {1'b0, x[idx]};
    cy   = {2'b0, y[idx]};
    dxn  = dx_neg[idx] ^ lat_h[idx];
    dyn  = dy_neg[idx] ^ lat_v[idx];
    nx   = x[idx];
    ny   = y[idx];
    ndx  = dxn;
    ndy  = dyn;
    gone = 1'b0;
    if (dxn) begin
      if (cx < HALF_W + SPD_W) begin nx = HALF_X; ndx = 1'b0; end
      else                          nx = x[idx] - SPD_X;
    end else begin
      if (cx + SPD_W > XMAX_W) begin nx = XMAX_X; ndx = 1'b1; end
      else                          nx = x[idx] + SPD_X;
    end
    if (dyn) begin
      if (cy < HALF_W + SPD_W) begin ny = HALF_Y; ndy = 1'b0; end
      else                          ny = y[idx] - SPD_Y;
    end else if (cy + SPD_W > YMAX_W) begin
      gone = 1'b1;
    end else begin
      ny = y[idx] + SPD_Y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      launch_ack <= 1'b0;
      lost       <= 1'b0;
      dx_neg     <= '0;
      dy_neg     <= '1;
      act        <= '0;
      lat_h      <= '0;
      lat_v      <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        x[i] <= 10'(SCREEN_W / 2);
        y[i] <= 9'(SCREEN_H / 2);
      end
    end else begin
      launch_ack <= launch_go;
      lost       <= 1'b0;
      lat_h      <= lat_h | hit_h;
      lat_v      <= lat_v | hit_v;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state <= S_UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end else if (launch_go) begin
            x[free_idx]      <= launch_x;
            y[free_idx]      <= launch_y;
            dx_neg[free_idx] <= 1'b0;
            dy_neg[free_idx] <= 1'b1;
            act[free_idx]    <= 1'b1;
            lat_h[free_idx]  <= 1'b0;
            lat_v[free_idx]  <= 1'b0;
          end
        end
        S_UPDATE: begin
          // A hit landing on the processing cycle survives into the next frame.
          lat_h[idx] <= hit_h[idx];
          lat_v[idx] <= hit_v[idx];
          if (act[idx]) begin
            if (gone) begin
              act[idx] <= 1'b0;
              lost     <= 1'b1;
            end else begin
              x[idx]      <= nx;
              y[idx]      <= ny;
              dx_neg[idx] <= ndx;
              dy_neg[idx] <= ndy;
            end
          end
          if (idx == IW'(NUM_BALLS - 1)) state <= S_DONE;
          else                           idx   <= idx + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [NUM_BALLS-1:0] slot_hit;
  logic [10:0]          h_w, v_w;
  assign h_w = {1'b0, hpos};
  assign v_w = {2'b0, vpos};

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_paint
    logic [10:0] px, py;
    logic        in_x, in_y, corner;
    assign px   = {1'b0, x[g]};
    assign py   = {2'b0, y[g]};
    assign in_x = (h_w + HALF_W >= px) && (h_w <= px + HALF_W);
    assign in_y = (v_w + HALF_W >= py) && (v_w <= py + HALF_W);
`ifdef BALL_ENGINE_ROUND_EN
    assign corner = ((h_w + HALF_W == px) || (h_w == px + HALF_W)) &&
                    ((v_w + HALF_W == py) || (v_w == py + HALF_W));
`else
    assign corner = 1'b0;
`endif
    assign slot_hit[g] = act[g] && in_x && in_y && !corner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ball <= 1'b0;
      color   <= 6'd0;
    end else begin
      in_ball <= |slot_hit;
      color   <= (|slot_hit) ? BALL_COLOR : 6'd0;
    end
  end

  assign active = act;
endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: random launches/hits/frames against a position-level model;
// expectations are queued by the driver and consumed by an independent negedge monitor.
module tb_ball_engine;
  localparam int N  = 2;
  localparam int BW = 5;
  localparam int H  = BW / 2;
  localparam int S  = 1;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam logic [5:0] COL = 6'b001100;

  logic         clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, launch = 1'b0;
  logic [9:0]   launch_x = '0, hpos = '0;
  logic [8:0]   launch_y = '0, vpos = '0;
  logic [N-1:0] hit_h = '0, hit_v = '0;
  logic         in_ball, launch_ack, lost, busy;
  logic [5:0]   color;
  logic [N-1:0] active;

  ball_engine #(.NUM_BALLS(N), .BALL_WIDTH(BW), .SPEED(S), .SCREEN_W(SW),
                .SCREEN_H(SH), .BALL_COLOR(COL)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch),
    .launch_x(launch_x), .launch_y(launch_y), .hit_h(hit_h), .hit_v(hit_v),
    .hpos(hpos), .vpos(vpos), .in_ball(in_ball), .color(color),
    .active(active), .launch_ack(launch_ack), .lost(lost), .busy(busy));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  typedef struct { int due; int kind; int val; } smp_t;
  smp_t smp_q[$];
  int   ack_q[$], lost_q[$];
  int   last_ack = -1, last_lost = -1;

  // Reference model: ball positions and directions as plain integers.
  int bx[N], by[N];
  bit bdxn[N], bdyn[N], bact[N], lh[N], lv[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      bx[i] = SW / 2; by[i] = SH / 2; bdxn[i] = 0; bdyn[i] = 1;
      bact[i] = 0; lh[i] = 0; lv[i] = 0;
    end
  endtask

  function automatic int act_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (bact[i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int paint(input int h, input int v);
    int dh, dv;
    for (int i = 0; i < N; i++) begin
      dh = (h > bx[i]) ? h - bx[i] : bx[i] - h;
      dv = (v > by[i]) ? v - by[i] : by[i] - v;
`ifdef BALL_ENGINE_ROUND_EN
      if (bact[i] && dh <= H && dv <= H && !(dh == H && dv == H)) return 1;
`else
      if (bact[i] && dh <= H && dv <= H) return 1;
`endif
    end
    return 0;
  endfunction

  task automatic push(input int due, input int kind, input int val);
    smp_t e;
    e.due = due; e.kind = kind; e.val = val;
    smp_q.push_back(e);
  endtask

  task automatic paint_exp(input int c, input int h, input int v);
    int p = paint(h, v);
    push(c + 1, 2, p);
    push(c + 1, 3, p ? int'(COL) : 0);
  endtask

  task automatic process_slot(input int i, input int c);
    if (!bact[i]) return;
    if (lh[i]) bdxn[i] = !bdxn[i];
    if (lv[i]) bdyn[i] = !bdyn[i];
    if (!bdyn[i] && by[i] + S > SH - 1) begin
      bact[i] = 0;
      lost_q.push_back(c + 1);
      return;
    end
    if (bdxn[i]) begin
      if (bx[i] < H + S) begin bx[i] = H; bdxn[i] = 0; end else bx[i] -= S;
    end else begin
      if (bx[i] + S > SW - 1 - H) begin bx[i] = SW - 1 - H; bdxn[i] = 1; end else bx[i] += S;
    end
    if (bdyn[i]) begin
      if (by[i] < H + S) begin by[i] = H; bdyn[i] = 0; end else by[i] -= S;
    end else by[i] += S;
  endtask

  task automatic pick_pix(output int h, output int v);
    int i = $urandom_range(N - 1, 0);
    if ($urandom_range(1, 0) == 1 && bact[i]) begin
      h = bx[i] + $urandom_range(6, 0) - 3;
      v = by[i] + $urandom_range(6, 0) - 3;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
    end else begin
      h = $urandom_range(SW - 1, 0);
      v = $urandom_range(SH - 1, 0);
    end
  endtask

  function automatic logic [N-1:0] rand_hits();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = ($urandom_range(7, 0) == 0);
    return r;
  endfunction

  task automatic idle_cyc(input bit ln, input int lx, input int ly, input bit tk,
                          input logic [N-1:0] hh, input logic [N-1:0] hv,
                          input int ph, input int pv);
    int c = cyc, h = ph, v = pv, s = -1;
    if (ph < 0) pick_pix(h, v);
    paint_exp(c, h, v);
    for (int i = 0; i < N; i++) begin
      lh[i] |= hh[i]; lv[i] |= hv[i];
    end
    if (ln && !tk) begin
      for (int i = N - 1; i >= 0; i--) if (!bact[i]) s = i;
      if (s >= 0) begin
        bx[s] = lx; by[s] = ly; bdxn[s] = 0; bdyn[s] = 1; bact[s] = 1;
        lh[s] = 0; lv[s] = 0;
        ack_q.push_back(c + 1);
      end
    end
    push(c + 1, 0, act_vec());
    hpos = 10'(h); vpos = 9'(v); launch = ln; launch_x = 10'(lx); launch_y = 9'(ly);
    frame_tick = tk; hit_h = hh; hit_v = hv;
    @(posedge clk); #1;
  endtask

  task automatic frame(input bit rnd, input logic [N-1:0] hv0);
    int c, h, v;
    logic [N-1:0] hh, hv;
    for (int j = 0; j <= N; j++) begin
      c = cyc;
      push(c, 1, 1);
      hh = rnd ? rand_hits() : '0;
      hv = rnd ? rand_hits() : ((j == 0) ? hv0 : '0);
      pick_pix(h, v);
      paint_exp(c, h, v);
      if (j < N) process_slot(j, c);
      for (int i = 0; i < N; i++) begin
        if (i == j) begin lh[i] = hh[i]; lv[i] = hv[i]; end
        else begin lh[i] |= hh[i]; lv[i] |= hv[i]; end
      end
      push(c + 1, 0, act_vec());
      hpos = 10'(h); vpos = 9'(v); hit_h = hh; hit_v = hv;
      launch = rnd && ($urandom_range(3, 0) == 0);
      launch_x = 10'($urandom_range(SW - 1 - H, H));
      launch_y = 9'($urandom_range(SH - 1, H));
      frame_tick = rnd && ($urandom_range(3, 0) == 0);
      @(posedge clk); #1;
    end
    push(cyc, 1, 0);
  endtask

  task automatic quiet(input int n);
    repeat (n) idle_cyc(0, 0, 0, 0, '0, '0, -1, -1);
  endtask

  task automatic tick_frame(input bit rnd, input logic [N-1:0] hv0);
    idle_cyc(0, 0, 0, 1, '0, '0, -1, -1);
    frame(rnd, hv0);
  endtask

  task automatic probe(input int i);
    for (int o = -3; o <= 3; o++) idle_cyc(0, 0, 0, 0, '0, '0, bx[i] + o, by[i]);
    for (int o = -3; o <= 3; o++) idle_cyc(0, 0, 0, 0, '0, '0, bx[i], by[i] + o);
  endtask

  task automatic do_reset();
    frame_tick = 0; launch = 0; hit_h = '0; hit_v = '0;
    rst = 1;
    smp_q.delete(); ack_q.delete(); lost_q.delete();
    push(cyc, 0, 0); push(cyc, 1, 0); push(cyc, 2, 0); push(cyc, 3, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  function automatic string kname(input int k);
    case (k)
      0: return "active";
      1: return "busy";
      2: return "in_ball";
      default: return "color";
    endcase
  endfunction

  // Monitor: consumes expectations whenever the DUT pulses or a sample is due.
  always @(negedge clk) begin
    int d;
    logic [31:0] got;
    if (launch_ack) begin
      last_ack = cyc;
      if (ack_q.size() > 0) begin d = ack_q.pop_front(); chk("launch_ack_cycle", cyc, d); end
      else chk("launch_ack_spurious", launch_ack, 0);
    end
    while (ack_q.size() > 0 && ack_q[0] < cyc) begin
      d = ack_q.pop_front(); chk("launch_ack_missing", last_ack, d);
    end
    if (lost) begin
      last_lost = cyc;
      if (lost_q.size() > 0) begin d = lost_q.pop_front(); chk("lost_cycle", cyc, d); end
      else chk("lost_spurious", lost, 0);
    end
    while (lost_q.size() > 0 && lost_q[0] < cyc) begin
      d = lost_q.pop_front(); chk("lost_missing", last_lost, d);
    end
    for (int i = smp_q.size() - 1; i >= 0; i--) begin
      if (smp_q[i].due == cyc) begin
        case (smp_q[i].kind)
          0: got = 32'(active);
          1: got = 32'(busy);
          2: got = 32'(in_ball);
          default: got = 32'(color);
        endcase
        chk(kname(smp_q[i].kind), got, smp_q[i].val);
        smp_q.delete(i);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic int rand_x();
    case ($urandom_range(2, 0))
      0: return H + $urandom_range(3, 0);
      1: return SW - 1 - H - $urandom_range(3, 0);
      default: return $urandom_range(SW - 1 - H, H);
    endcase
  endfunction

  function automatic int rand_y();
    case ($urandom_range(2, 0))
      0: return H + $urandom_range(3, 0);
      1: return SH - 1 - $urandom_range(3, 0);
      default: return $urandom_range(SH - 1, H);
    endcase
  endfunction

  initial begin
    bit ln, tk;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // First launch, one quiet frame, probe the stepped position.
    idle_cyc(1, 100, 200, 0, '0, '0, -1, -1);
    quiet(2);
    tick_frame(0, '0);
    probe(0);

    // Fill slot 1, then a launch with no free slot.
    idle_cyc(1, 400, 300, 0, '0, '0, -1, -1);
    idle_cyc(1, 50, 60, 0, '0, '0, -1, -1);
    // Launch coinciding with frame_tick is dropped.
    idle_cyc(1, 10, 10, 1, '0, '0, -1, -1);
    frame(0, '0);

    // Sticky v hit before the frame plus a hit on slot 0's update cycle.
    idle_cyc(0, 0, 0, 0, '0, 2'b01, -1, -1);
    tick_frame(0, 2'b01);
    probe(0);
    tick_frame(0, '0);
    probe(0);

    // Left wall approach.
    do_reset();
    idle_cyc(1, 3, 200, 0, '0, '0, -1, -1);
    idle_cyc(0, 0, 0, 0, 2'b01, '0, -1, -1);
    repeat (3) begin tick_frame(0, '0); probe(0); end

    // Bottom loss and slot reuse.
    do_reset();
    idle_cyc(1, 100, 478, 0, '0, '0, -1, -1);
    idle_cyc(0, 0, 0, 0, '0, 2'b01, -1, -1);
    repeat (2) tick_frame(0, '0);
    idle_cyc(1, 200, 100, 0, '0, '0, -1, -1);
    probe(0);

    // Paint footprint at screen centre.
    do_reset();
    idle_cyc(1, 320, 240, 0, '0, '0, -1, -1);
    for (int h = 316; h <= 324; h++) idle_cyc(0, 0, 0, 0, '0, '0, h, 240);
    for (int v = 236; v <= 244; v++) idle_cyc(0, 0, 0, 0, '0, '0, 320, v);
    idle_cyc(0, 0, 0, 0, '0, '0, 318, 238);
    idle_cyc(0, 0, 0, 0, '0, '0, 322, 242);
    idle_cyc(0, 0, 0, 0, '0, '0, 323, 242);

    // Randomized traffic.
    repeat (400) begin
      ln = ($urandom_range(2, 0) == 0);
      tk = ($urandom_range(2, 0) == 0);
      idle_cyc(ln, rand_x(), rand_y(), tk, rand_hits(), rand_hits(), -1, -1);
      if (tk) frame(1, '0);
    end

    // Reset while a frame update is in flight.
    idle_cyc(1, 300, 300, 0, '0, '0, -1, -1);
    idle_cyc(0, 0, 0, 1, '0, '0, -1, -1);
    frame_tick = 0; launch = 0; hit_h = '0; hit_v = '0;
    rst = 1;
    for (int i = smp_q.size() - 1; i >= 0; i--) if (smp_q[i].due >= cyc) smp_q.delete(i);
    lost_q.delete();
    push(cyc, 0, 0); push(cyc, 1, 0); push(cyc, 2, 0); push(cyc, 3, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    quiet(4);
    idle_cyc(1, 120, 130, 0, '0, '0, -1, -1);
    quiet(3);

    frame_tick = 0; launch = 0; hit_h = '0; hit_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("lost_queue_drained", lost_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
